// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read port between the fetch stage and instruction memory.
interface fetch_unit_if;
   logic [31:0] i_inst_addr;
   logic [31:0] i_inst_rdata;
   modport master (output i_inst_addr, input i_inst_rdata);
   modport slave  (input i_inst_addr, output i_inst_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register with prioritised redirect and combinational AdEL detection.
module fetch_unit #(
   parameter logic [31:0] INIT_PC    = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_LO      = 32'h0000_3000,
   parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         exc_req,
   input  logic         eret_en,
   input  logic [31:0]  epc,
   input  logic         br_taken,
   input  logic [31:0]  br_target,
   fetch_unit_if.master imem,
   output logic [31:0]  F_PC,
   output logic [31:0]  F_instr,
   output logic [4:0]   F_ExcCode
);
   logic [31:0] r_pc = INIT_PC;
   logic [31:0] w_next_pc;
   logic        w_adel;
   // exc/eret outrank stall so CP0 redirects are never lost behind a hazard
   assign w_next_pc = exc_req ? HANDLER_PC :
                      eret_en ? epc :
                      stall ? r_pc :
                      br_taken ? br_target : r_pc + 32'd4;
   assign w_adel = (|r_pc[1:0]) || (r_pc < IM_LO) || (r_pc > IM_HI);
   always_ff @(posedge clk) r_pc <= reset ? INIT_PC : w_next_pc;
   assign F_PC             = r_pc;
   assign imem.i_inst_addr = r_pc;
   assign F_ExcCode        = w_adel ? 5'd4 : 5'd0;
   assign F_instr          = w_adel ? 32'h0000_0000 : imem.i_inst_rdata;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit redirect priority, stall, reset and AdEL.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        exc_req = 1'b0;
   logic        eret_en = 1'b0;
   logic [31:0] epc = '0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic [31:0] F_PC, F_instr;
   logic [4:0]  F_ExcCode;
   int          total = 0;
   int          bad = 0;
   typedef struct {
      logic [31:0] pc;
      logic [4:0]  ec;
      logic [31:0] ins;
   } exp_t;
   exp_t        sb[$];
   logic [31:0] m_pc = 32'h0000_3000;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .exc_req   (exc_req),
      .eret_en   (eret_en),
      .epc       (epc),
      .br_taken  (br_taken),
      .br_target (br_target),
      .imem      (bus.master),
      .F_PC      (F_PC),
      .F_instr   (F_instr),
      .F_ExcCode (F_ExcCode)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   assign bus.i_inst_rdata = mem(bus.i_inst_addr);

   function automatic logic adel(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic rs, input logic st, input logic ex, input logic er,
                       input logic [31:0] ep, input logic br, input logic [31:0] tg);
      exp_t e;
      @(negedge clk);
      reset = rs; stall = st; exc_req = ex; eret_en = er; epc = ep; br_taken = br; br_target = tg;
      m_pc = rs ? 32'h0000_3000 : ex ? 32'h0000_4180 : er ? ep : st ? m_pc : br ? tg : m_pc + 32'd4;
      e.pc  = m_pc;
      e.ec  = adel(m_pc) ? 5'd4 : 5'd0;
      e.ins = adel(m_pc) ? 32'h0 : mem(m_pc);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc", F_PC, e.pc);
      chk("addr", bus.i_inst_addr, e.pc);
      chk("exc", {27'd0, F_ExcCode}, {27'd0, e.ec});
      chk("instr", F_instr, e.ins);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1;
      chk("t0_pc", F_PC, 32'h3000);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("rst_pc", F_PC, 32'h3000);
      chk("rst_instr", F_instr, mem(32'h3000));
      idle(); chk("idle1", F_PC, 32'h3004);
      idle(); chk("idle2", F_PC, 32'h3008);
      idle(); chk("idle3", F_PC, 32'h300C);
      idle(); chk("pc3010", F_PC, 32'h3010);
      step(0, 1, 0, 0, 0, 1, 32'h3400); chk("stall1", F_PC, 32'h3010);
      step(0, 1, 0, 0, 0, 1, 32'h3400); chk("stall2", F_PC, 32'h3010);
      step(0, 0, 0, 0, 0, 1, 32'h3400); chk("br_after", F_PC, 32'h3400);
      step(0, 0, 0, 0, 0, 1, 32'h3020);
      step(0, 1, 1, 0, 0, 0, 0); chk("exc_ovr", F_PC, 32'h4180);
      step(0, 1, 0, 1, 32'h3024, 1, 32'h3400); chk("eret_ovr", F_PC, 32'h3024);
      step(0, 0, 0, 0, 0, 1, 32'h3002);
      chk("mis_pc", F_PC, 32'h3002);
      chk("mis_exc", {27'd0, F_ExcCode}, 32'd4);
      chk("mis_ins", F_instr, 32'h0);
      step(0, 1, 0, 0, 0, 0, 0); chk("held_exc", {27'd0, F_ExcCode}, 32'd4);
      step(0, 0, 0, 0, 0, 1, 32'h7000); chk("oor_exc", {27'd0, F_ExcCode}, 32'd4);
      step(0, 0, 0, 1, 32'h2FFC, 0, 0); chk("bad_epc", {27'd0, F_ExcCode}, 32'd4);
      step(0, 0, 1, 1, 32'h3024, 0, 0); chk("exc_eret", F_PC, 32'h4180);
      step(1, 0, 1, 0, 0, 0, 0); chk("rst_exc", F_PC, 32'h3000);
      idle();
      step(1, 1, 0, 1, 32'h5000, 1, 32'h3400); chk("rst_mid", F_PC, 32'h3000);
      step(0, 0, 0, 0, 0, 1, 32'h6FFC); chk("hi_exc", {27'd0, F_ExcCode}, 32'd0);
      idle();
      chk("over_pc", F_PC, 32'h7000);
      chk("over_exc", {27'd0, F_ExcCode}, 32'd4);
      chk("over_ins", F_instr, 32'h0);
      step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      idle(); chk("wrap", F_PC, 32'h0);
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 15);
         step(r == 15, r < 3, r == 3, r == 4, 32'h3000 + ($urandom_range(0, 4095) << 2),
              r == 5 || r == 6, (r == 6) ? $urandom : 32'h3000 + ($urandom_range(0, 4095) << 2));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
